alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Two-requester arbiter that time-shares the single combinational ALU.
  - Requester 0: pipeline EX stage.
  - Requester 1: auxiliary unit, e.g. CP0 or address generation.
- Drives the ALU operand and op inputs from the granted request, then registers the result, overflow and tag into a one-entry response buffer per requester.
- Uses valid/ready handshakes on both the request side and the response side, so either requester can stall without blocking the other once its slot is free.

Parameters:
- TAG_W, 4, width of the opaque tag carried from request to response.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (requester 0 always wins).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_a / req1_a  in  32  operand A (ALU srcA).
- req0_b / req1_b  in  32  operand B (ALU srcB).
- req0_op / req1_op  in  4  ALU op code (constant.v encoding).
- req0_tag / req1_tag  in  TAG_W  returned unchanged with the response.
- resp0_valid / resp1_valid  out  1  response slot full.
- resp0_ready / resp1_ready  in  1  consumer takes the response.
- resp0_result / resp1_result  out  32  captured ALU result.
- resp0_ovf / resp1_ovf  out  1  captured overflow (see Optional Feature).
- resp0_tag / resp1_tag  out  TAG_W  captured tag.
- alu_a, alu_b  out  32  to ALU srcA/srcB.
- alu_op  out  4  to ALU ALUOp.
- alu_result  in  32  from ALU.
- alu_ovf  in  1  from ALU overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all resp*_valid=0, resp*_result=0, resp*_ovf=0, resp*_tag=0.
  - Round-robin pointer last=1, so requester 0 wins the first contention.
  - Reset mid-operation discards buffered responses. No acceptance occurs while rst_n is low.
- Eligibility: elig_i = !resp_i_valid | resp_i_ready. A slot may refill in the cycle it drains.
- Grant (combinational):
  - cand_i = req_i_valid & elig_i.
  - Only one candidate: it wins.
  - Both candidates: ARB_MODE=0 grants the requester != last; ARB_MODE=1 grants requester 0.
  - req_i_ready = grant_i. Ready may depend on the other requester's valid. A requester must never make its valid depend on its own ready.
- ALU drive:
  - With a grant: alu_a/alu_b/alu_op = granted request fields.
  - No grant: alu_a=0, alu_b=0, alu_op=4'b0000.
- Capture: on the posedge where req_i_valid & req_i_ready, slot i loads alu_result, ovf and tag, and sets resp_i_valid=1. Latency is exactly 1 cycle: accept at edge N, response visible after edge N.
- Drain: resp_i_valid & resp_i_ready with no same-edge refill clears resp_i_valid. Data registers hold their last value.
- Simultaneous drain and refill of the same slot: the new data wins and resp_i_valid stays 1.
- Pointer: last updates to the granted index only on an actual accept. It is unchanged on idle cycles.
- Throughput: 1 op/cycle total. A requester whose consumer holds resp_ready=0 is blocked (ready=0) and does not consume ALU slots. The other requester then gets every cycle.
- Per-slot states are EMPTY and FULL:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on drain without refill.
  - FULL to FULL on drain with refill.
- No combinational path from resp*_ready to resp*_valid/data. A combinational path from resp*_ready to req*_ready exists by design.

Optional Feature:
- Macro ALU_ARB_OVF_EN.
- Defined: resp_i_ovf captures alu_ovf only when the granted op is `aluAdd or `aluSub; other ops capture 0.
- Undefined: resp_i_ovf is a constant 0, the alu_ovf input is ignored, and no ovf flops are built. The port list is unchanged.

Test Plan:
- Single op: req0 a=7 b=5 op=`aluAdd tag=3 -> req0_ready=1 same cycle; next cycle resp0_valid=1, result=12, ovf=0, tag=3.
- Contention, ARB_MODE=0, both valid continuously, resp ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset. Each response arrives 1 cycle after its grant.
- Backpressure: resp0_ready=0 with slot 0 full, req0 and req1 both valid -> req0_ready=0 and req1 granted every cycle. Raising resp0_ready accepts req0 in the same cycle.
- Overflow with ALU_ARB_OVF_EN: a=32'h7FFFFFFF b=1 `aluAdd -> result=32'h80000000, ovf=1. Same operands with op=`aluOr -> ovf=0. Without the macro, ovf=0 in both cases.
- Fixed priority, ARB_MODE=1, both valid for 4 cycles -> requester 0 granted 4/4 and req1_ready=0 throughout.
- Reset mid-stream: assert rst_n=0 asynchronously while resp1_valid=1 -> resp1_valid drops immediately without waiting for clk. After release, the first contention grants requester 0.

Source files
------------

// File: rtl/alu_share_arb.sv
// Two-requester arbiter time-sharing one combinational ALU, with a one-entry response buffer per requester.
// Optional macro ALU_ARB_OVF_EN: capture ALU overflow for add/sub ops; otherwise resp*_ovf is tied to 0.

`ifndef aluAdd
`define aluAdd 4'b0001
`endif
`ifndef aluSub
`define aluSub 4'b0010
`endif

module alu_share_arb #(
  parameter int TAG_W    = 4,
  parameter int ARB_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [31:0]      resp0_result,
  output logic             resp0_ovf,
  output logic [TAG_W-1:0] resp0_tag,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [31:0]      resp1_result,
  output logic             resp1_ovf,
  output logic [TAG_W-1:0] resp1_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_result,
  input  logic             alu_ovf
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;

  logic [1:0]       req_valid;
  logic [1:0]       resp_ready;
  logic [1:0]       resp_valid;
  logic [1:0]       elig;
  logic [1:0]       cand;
  logic [1:0]       grant;
  logic [1:0]       resp_ovf;
  logic [31:0]      req_a      [2];
  logic [31:0]      req_b      [2];
  logic [3:0]       req_op     [2];
  logic [TAG_W-1:0] req_tag    [2];
  logic [31:0]      resp_result[2];
  logic [TAG_W-1:0] resp_tag   [2];
  logic             last_reg;
  logic             last_next;
  logic             ovf_capture;

  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};
  assign req_a[0]   = req0_a;
  assign req_a[1]   = req1_a;
  assign req_b[0]   = req0_b;
  assign req_b[1]   = req1_b;
  assign req_op[0]  = req0_op;
  assign req_op[1]  = req1_op;
  assign req_tag[0] = req0_tag;
  assign req_tag[1] = req1_tag;

  // A slot can take a new result if empty or being drained on this same edge.
  assign elig = ~resp_valid | resp_ready;
  assign cand = req_valid & elig;

  always_comb begin
    grant = 2'b00;
    case (cand)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (ARB_MODE == 1) grant = 2'b01;
        else               grant = last_reg ? 2'b01 : 2'b10;
      end
      default: grant = 2'b00;
    endcase
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_op = 4'b0000;
    if (grant[0]) begin
      alu_a  = req_a[0];
      alu_b  = req_b[0];
      alu_op = req_op[0];
    end else if (grant[1]) begin
      alu_a  = req_a[1];
      alu_b  = req_b[1];
      alu_op = req_op[1];
    end
  end

`ifdef ALU_ARB_OVF_EN
  assign ovf_capture = alu_ovf & ((alu_op == `aluAdd) || (alu_op == `aluSub));
`else
  logic unused_alu_ovf;
  assign unused_alu_ovf = alu_ovf;
  assign ovf_capture    = 1'b0;
`endif

  assign last_next = (|grant) ? grant[1] : last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_reg <= 1'b1;
    else        last_reg <= last_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_slot
      slot_state_e      state_reg;
      slot_state_e      state_next;
      logic [31:0]      result_reg;
      logic [TAG_W-1:0] tag_reg;

      always_comb begin
        state_next = state_reg;
        if (grant[gi])
          state_next = FULL;
        else if (state_reg == FULL && resp_ready[gi])
          state_next = EMPTY;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg  <= EMPTY;
          result_reg <= 32'd0;
          tag_reg    <= '0;
        end else begin
          state_reg <= state_next;
          if (grant[gi]) begin
            result_reg <= alu_result;
            tag_reg    <= req_tag[gi];
          end
        end
      end

`ifdef ALU_ARB_OVF_EN
      logic ovf_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ovf_reg <= 1'b0;
        else if (grant[gi]) ovf_reg <= ovf_capture;
      end
      assign resp_ovf[gi] = ovf_reg;
`else
      assign resp_ovf[gi] = ovf_capture;
`endif

      assign resp_valid[gi]  = (state_reg == FULL);
      assign resp_result[gi] = result_reg;
      assign resp_tag[gi]    = tag_reg;
    end
  endgenerate

  assign resp0_valid  = resp_valid[0];
  assign resp1_valid  = resp_valid[1];
  assign resp0_result = resp_result[0];
  assign resp1_result = resp_result[1];
  assign resp0_ovf    = resp_ovf[0];
  assign resp1_ovf    = resp_ovf[1];
  assign resp0_tag    = resp_tag[0];
  assign resp1_tag    = resp_tag[1];

endmodule
